rijndael_keyexpansion: RTL and testbench

Iterative, word-serial Rijndael key-expansion engine parametrised over key length (NK = 4/6/8, i.e. AES-128/192/256). It accepts a cipher key through a valid/ready start handshake, generates one 32-bit expanded-key word per cycle with an internal Rcon generator, and streams the NR+1 128-bit round keys out over a valid/ready interface. It sits between the key-load logic and the round datapath and replaces per-round combinational key-step instances.

---
 rtl/rijndael_keyexpansion_if.sv | 43 ++++
 rtl/rijndael_keyexpansion.sv | 197 +++++++++++++++++++
 tb/tb_rijndael_keyexpansion.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rijndael_keyexpansion_if.sv
// Handshake/bus bundle for rijndael_keyexpansion: start handshake with
// cipher key, round-key stream, status. Optional abort input is present
// only when RIJNDAEL_KS_ABORT_EN is defined.
interface rijndael_keyexpansion_if #(
  parameter int NK = 4
);
  logic              start_valid;
  logic              start_ready;
  logic [32*NK-1:0]  key_in;
  logic              rk_valid;
  logic              rk_ready;
  logic [127:0]      rk_data;
  logic [3:0]        rk_index;
  logic              rk_last;
  logic              busy;
`ifdef RIJNDAEL_KS_ABORT_EN
  logic              abort;

  // Key-load / round-key consumer side
  modport master (
    output start_valid, key_in, rk_ready, abort,
    input  start_ready, rk_valid, rk_data, rk_index, rk_last, busy
  );

  // Key-expansion engine side
  modport slave (
    input  start_valid, key_in, rk_ready, abort,
    output start_ready, rk_valid, rk_data, rk_index, rk_last, busy
  );
`else
  // Key-load / round-key consumer side
  modport master (
    output start_valid, key_in, rk_ready,
    input  start_ready, rk_valid, rk_data, rk_index, rk_last, busy
  );

  // Key-expansion engine side
  modport slave (
    input  start_valid, key_in, rk_ready,
    output start_ready, rk_valid, rk_data, rk_index, rk_last, busy
  );
`endif
endinterface

// File: rtl/rijndael_keyexpansion.sv
// Word-serial Rijndael key expansion (NK = 4/6/8). One expanded-key word is
// produced per advancing cycle; four words are collected into a 128-bit
// round key streamed out over valid/ready.
// Optional feature: define RIJNDAEL_KS_ABORT_EN to add a synchronous abort.

// Rijndael S-box computed as GF(2^8) inverse followed by the affine map.
module rijndael_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse (and maps 0 to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv;
  endfunction

  logic [7:0] w_inv;

  // Inverse then affine transform
  always_comb begin
    w_inv  = gf_inv(i_byte);
    o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
           ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
  end
endmodule

module rijndael_keyexpansion #(
  parameter int NK = 4
) (
  input logic clk,
  input logic rst_n,
  rijndael_keyexpansion_if.slave ks
);
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  if (NK != 4 && NK != 6 && NK != 8) begin : g_nk_check
    $error("rijndael_keyexpansion: NK must be 4, 6 or 8");
  end

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t       r_state;
  logic [31:0]  r_win [NK];   // r_win[0] = w[i-NK], r_win[NK-1] = w[i-1]
  logic [5:0]   r_i;          // word counter
  logic [2:0]   r_phase;      // i mod NK
  logic [7:0]   r_rcon;
  logic [95:0]  r_coll;       // slots 0..2 of the round key in progress
  logic [127:0] r_rk_data;
  logic [3:0]   r_rk_index;
  logic         r_rk_valid;
  logic         r_rk_last;
  logic         r_busy;

  logic         w_abort;
  logic         w_advance;
  logic         w_handshake;
  logic         w_is_rcon;
  logic         w_is_sub8;
  logic [31:0]  w_key_word;
  logic [31:0]  w_sub_in;
  logic [31:0]  w_sub_out;
  logic [31:0]  w_word;

`ifdef RIJNDAEL_KS_ABORT_EN
  assign w_abort = ks.abort;
`else
  assign w_abort = 1'b0;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  assign w_handshake = r_rk_valid && ks.rk_ready;
  assign w_advance   = (r_state == S_RUN) && (r_i < 6'(NW)) && (!r_rk_valid || ks.rk_ready);
  assign w_is_rcon   = (r_i >= 6'(NK)) && (r_phase == 3'd0);
  assign w_is_sub8   = (NK == 8) && (r_i >= 6'(NK)) && (r_phase == 3'd4);
  // RotWord only on the Rcon step; the NK=8 mid-step substitutes w[i-1] directly
  assign w_sub_in    = w_is_rcon ? {r_win[NK-1][23:0], r_win[NK-1][31:24]} : r_win[NK-1];

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    rijndael_sbox u_sbox (
      .i_byte (w_sub_in[8*gi +: 8]),
      .o_byte (w_sub_out[8*gi +: 8])
    );
  end

  // Select the next expanded-key word
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_key_word = '0;
    for (int k = 0; k < NK; k++) begin
      if (r_i == 6'(k)) w_key_word = r_win[k];
    end
    if (r_i < 6'(NK))   w_word = w_key_word;
    else if (w_is_rcon) w_word = r_win[0] ^ w_sub_out ^ {r_rcon, 24'h0};
    else if (w_is_sub8) w_word = r_win[0] ^ w_sub_out;
    else                w_word = r_win[0] ^ r_win[NK-1];
  end

  // Control FSM, word generation, collector and round-key output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the key window is a small register file, not a RAM, so it is cleared with everything else.
      r_state    <= S_IDLE;
      for (int k = 0; k < NK; k++) r_win[k] <= '0;
      r_i        <= '0;
      r_phase    <= '0;
      r_rcon     <= '0;
      r_coll     <= '0;
      r_rk_data  <= '0;
      r_rk_index <= '0;
      r_rk_valid <= 1'b0;
      r_rk_last  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        S_IDLE: begin
          if (ks.start_valid) begin
            r_state <= S_RUN;
            for (int k = 0; k < NK; k++) r_win[k] <= ks.key_in[32*k +: 32];
            r_i     <= '0;
            r_phase <= '0;
            r_rcon  <= 8'h01;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_abort) begin
            r_state    <= S_IDLE;
            r_rk_valid <= 1'b0;
            r_rk_last  <= 1'b0;
            r_busy     <= 1'b0;
          end else begin
            if (w_handshake) begin
              r_rk_valid <= 1'b0;
              r_rk_last  <= 1'b0;
              if (r_rk_last) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end
            if (w_advance) begin
              r_i     <= r_i + 6'd1;
              r_phase <= (r_phase == 3'(NK - 1)) ? 3'd0 : r_phase + 3'd1;
              if (r_i >= 6'(NK)) begin
                for (int k = 0; k < NK - 1; k++) r_win[k] <= r_win[k+1];
                r_win[NK-1] <= w_word;
              end
              if (w_is_rcon) r_rcon <= xtime(r_rcon);
              case (r_i[1:0])
                2'd0: r_coll[31:0]  <= w_word;
                2'd1: r_coll[63:32] <= w_word;
                2'd2: r_coll[95:64] <= w_word;
                default: begin
                  r_rk_data  <= {w_word, r_coll};
                  r_rk_index <= r_i[5:2];
                  r_rk_valid <= 1'b1;
                  r_rk_last  <= (r_i[5:2] == 4'(NR));
                end
              endcase
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ks.start_ready = (r_state == S_IDLE);
  assign ks.rk_valid    = r_rk_valid;
  assign ks.rk_data     = r_rk_data;
  assign ks.rk_index    = r_rk_index;
  assign ks.rk_last     = r_rk_last;
  assign ks.busy        = r_busy;
endmodule

// File: tb/tb_rijndael_keyexpansion.sv
// Testbench for rijndael_keyexpansion: one instance per key length, driven
// one at a time through a shared stimulus bus; expected round keys come from
// a table-driven FIPS-197 key-schedule model.
module tb_rijndael_keyexpansion;
  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  localparam logic [7:0] RCON [10] = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};

  localparam logic [255:0] KEY_A1 = {128'd0,
    32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
  localparam logic [255:0] KEY_A2 = {64'd0,
    32'h522c6b7b, 32'h62f8ead2, 32'h809079e5, 32'hc810f32b, 32'hda0e6452, 32'h8e73b0f7};
  localparam logic [255:0] KEY_A3 = {
    32'h0914dff4, 32'h2d9810a3, 32'h3b6108d7, 32'h1f352c07,
    32'h857d7781, 32'h2b73aef0, 32'h15ca71be, 32'h603deb10};
  localparam int BUDGET = 1000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         rk_ready;
  logic         abort;
  logic [255:0] key_bus;
  int           sel;

  logic         obs_valid, obs_last, obs_busy, obs_start_ready;
  logic [127:0] obs_data;
  logic [3:0]   obs_index;

  int           checks = 0;
  int           errors = 0;
  int           cur_nr;
  logic [31:0]  ref_w [60];
  logic [127:0] got_rk [15];

  always #5 clk = ~clk;

  rijndael_keyexpansion_if #(.NK(4)) if4 ();
  rijndael_keyexpansion_if #(.NK(6)) if6 ();
  rijndael_keyexpansion_if #(.NK(8)) if8 ();

  assign if4.start_valid = start_valid && (sel == 0);
  assign if6.start_valid = start_valid && (sel == 1);
  assign if8.start_valid = start_valid && (sel == 2);
  assign if4.key_in      = key_bus[127:0];
  assign if6.key_in      = key_bus[191:0];
  assign if8.key_in      = key_bus;
  assign if4.rk_ready    = rk_ready;
  assign if6.rk_ready    = rk_ready;
  assign if8.rk_ready    = rk_ready;
`ifdef RIJNDAEL_KS_ABORT_EN
  assign if4.abort       = abort;
  assign if6.abort       = abort;
  assign if8.abort       = abort;
`endif

  rijndael_keyexpansion #(.NK(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .ks(if4.slave));
  rijndael_keyexpansion #(.NK(6)) u_dut6 (.clk(clk), .rst_n(rst_n), .ks(if6.slave));
  rijndael_keyexpansion #(.NK(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .ks(if8.slave));

  // Route the selected instance's outputs onto the observation bus
  always_comb begin
    obs_valid = if4.rk_valid; obs_last = if4.rk_last; obs_busy = if4.busy;
    obs_start_ready = if4.start_ready; obs_data = if4.rk_data; obs_index = if4.rk_index;
    if (sel == 1) begin
      obs_valid = if6.rk_valid; obs_last = if6.rk_last; obs_busy = if6.busy;
      obs_start_ready = if6.start_ready; obs_data = if6.rk_data; obs_index = if6.rk_index;
    end else if (sel == 2) begin
      obs_valid = if8.rk_valid; obs_last = if8.rk_last; obs_busy = if8.busy;
      obs_start_ready = if8.start_ready; obs_data = if8.rk_data; obs_index = if8.rk_index;
    end
  end

  task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // FIPS-197 KeyExpansion over a plain word array
  task automatic ref_expand(input int nk, input logic [255:0] key);
    logic [31:0] t;
    cur_nr = nk + 6;
    for (int i = 0; i < 60; i++) ref_w[i] = '0;
    for (int i = 0; i < nk; i++) ref_w[i] = key[32*i +: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = ref_w[i-1];
      if (i % nk == 0)                 t = sub_word({t[23:0], t[31:24]}) ^ {RCON[i/nk - 1], 24'h0};
      else if (nk == 8 && i % nk == 4) t = sub_word(t);
      ref_w[i] = ref_w[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] ref_rk(input int r);
    return {ref_w[4*r+3], ref_w[4*r+2], ref_w[4*r+1], ref_w[4*r]};
  endfunction

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  task automatic check_idle_reset(input string tag);
    check({tag, " flags"}, 128'({obs_valid, obs_last, obs_busy, obs_start_ready, obs_index}),
          128'({1'b0, 1'b0, 1'b0, 1'b1, 4'd0}));
    check({tag, " rk_data"}, obs_data, 128'd0);
  endtask

  // Called at a sample point; the start is accepted at the next edge
  task automatic do_start();
    check("start_ready before start", 128'(obs_start_ready), 128'(1));
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    check("busy/start_ready after start", 128'({obs_busy, obs_start_ready}), 128'(2'b10));
  endtask

  // Follow the round-key stream from round r_first; edges counted from the call
  task automatic collect(input int r_first, input bit rand_rdy, input bit timing,
                         input bit poke, input int stop_round);
    int r;
    int edges;
    bit done;
    r = r_first; edges = 0; done = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      edges++;
      if (poke && edges == 6) begin key_bus = rand_key(); start_valid = 1'b1; end
      if (poke && edges == 9) start_valid = 1'b0;
      if (edges > BUDGET) begin
        check("cycle budget", 128'(edges), 128'(BUDGET));
        done = 1'b1;
      end else begin
        if (rand_rdy) rk_ready = 1'($urandom_range(0, 1));
        if (obs_valid) begin
          if (r > cur_nr) begin
            check("extra round key valid", 128'(obs_valid), 128'(0));
            done = 1'b1;
          end else begin
            check("rk_data", obs_data, ref_rk(r));
            check("rk_index", 128'(obs_index), 128'(r));
            check("rk_last", 128'(obs_last), 128'(r == cur_nr));
            if (timing) check("rk_valid latency", 128'(edges), 128'(4 * (r - r_first + 1)));
            got_rk[r] = obs_data;
            if (r == stop_round) done = 1'b1;
            else if (rk_ready) begin
              if (r == cur_nr) begin
                @(posedge clk); #1;
                check("busy/start_ready/valid after last", 128'({obs_busy, obs_start_ready, obs_valid}),
                      128'(3'b010));
                done = 1'b1;
              end
              r++;
            end
          end
        end
      end
    end
  endtask

  task automatic run_key(input int nk_sel, input logic [255:0] key, input bit rand_rdy, input bit timing);
    sel = nk_sel;
    ref_expand(4 + 2 * nk_sel, key);
    key_bus = key;
    do_start();
    collect(0, rand_rdy, timing, 1'b0, -1);
  endtask

  initial begin
    int edges;
    logic [255:0] k;
    rst_n = 1'b0; start_valid = 1'b0; rk_ready = 1'b0; abort = 1'b0; key_bus = '0; sel = 0;
    repeat (2) @(posedge clk);
    #1 check_idle_reset("in reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_reset("after reset");

    // FIPS-197 A.1, free-running consumer
    rk_ready = 1'b1;
    run_key(0, KEY_A1, 1'b0, 1'b1);
    check("A.1 r1", got_rk[1], {32'h2a6c7605, 32'h23a33939, 32'h88542cb1, 32'ha0fafe17});
    check("A.1 r10", got_rk[10], {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8});

    // FIPS-197 A.2
    run_key(1, KEY_A2, 1'b0, 1'b1);
    check("A.2 w6", 128'(got_rk[1][95:64]), 128'(32'hfe0c91f7));
    check("A.2 r12", got_rk[12], {32'h01002202, 32'h8ecc7204, 32'h448c773c, 32'he98ba06f});

    // FIPS-197 A.3
    run_key(2, KEY_A3, 1'b0, 1'b1);
    check("A.3 w8..w11", got_rk[2], {32'h2067fcde, 32'ha51a8b5f, 32'h8e6925af, 32'h9ba35411});
    check("A.3 w12", 128'(got_rk[3][31:0]), 128'(32'ha8b09c1a));
    check("A.3 r14", got_rk[14], {32'h706c631e, 32'h046df344, 32'he6188d0b, 32'hfe4890d1});

    // Backpressure: hold r0 for 10 cycles
    sel = 0;
    ref_expand(4, KEY_A1);
    key_bus = KEY_A1;
    rk_ready = 1'b0;
    do_start();
    edges = 0;
    while (!obs_valid && edges <= 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check("backpressure r0 latency", 128'(edges), 128'(4));
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("stall rk_data", obs_data, KEY_A1[127:0]);
      check("stall valid/index", 128'({obs_valid, obs_index}), 128'({1'b1, 4'd0}));
    end
    rk_ready = 1'b1;
    collect(1, 1'b0, 1'b1, 1'b0, -1);

    // Start while busy is ignored; then reset at r5
    sel = 0;
    ref_expand(4, KEY_A1);
    key_bus = KEY_A1;
    do_start();
    collect(0, 1'b0, 1'b1, 1'b1, 5);
    rst_n = 1'b0;
    #2;
    check_idle_reset("async reset mid-run");
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    edges = 0;
    for (int c = 0; c < 8; c++) begin
      if (obs_valid) edges++;
      @(posedge clk); #1;
    end
    check("no partial key after reset", 128'(edges), 128'(0));
    run_key(0, rand_key(), 1'b0, 1'b1);

    // Random keys with random consumer backpressure
    for (int s = 0; s < 3; s++) begin
      for (int n = 0; n < 2; n++) begin
        k = rand_key();
        run_key(s, k, 1'b1, 1'b0);
      end
    end
    rk_ready = 1'b1;

`ifdef RIJNDAEL_KS_ABORT_EN
    // Abort while r3 is valid wins over the simultaneous handshake
    sel = 0;
    ref_expand(4, KEY_A1);
    key_bus = KEY_A1;
    do_start();
    collect(0, 1'b0, 1'b1, 1'b0, 3);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("after abort", 128'({obs_valid, obs_last, obs_busy, obs_start_ready}), 128'(4'b0001));
    run_key(0, KEY_A1, 1'b0, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
